l15_port_arbiter: RTL and testbench

//  Shares the single core->L1.5 (OpenPiton) request/response port between two requesters:

---
 rtl/l15_port_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_l15_port_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l15_port_arbiter.sv
// Round-robin arbiter sharing the single core->L1.5 request/response port between
// instruction fetch (requester 0) and the data memory FSM (requester 1).
module l15_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        rq0_val,
    input  logic [3:0]  rq0_rqtype,
    input  logic [2:0]  rq0_size,
    input  logic [31:0] rq0_address,
    input  logic [31:0] rq0_data,
    output logic        rq0_ack,
    output logic        rsp0_val,
    output logic [3:0]  rsp0_returntype,
    output logic [63:0] rsp0_data_0,
    output logic [63:0] rsp0_data_1,
    output logic        rsp0_timeout,

    input  logic        rq1_val,
    input  logic [3:0]  rq1_rqtype,
    input  logic [2:0]  rq1_size,
    input  logic [31:0] rq1_address,
    input  logic [31:0] rq1_data,
    output logic        rq1_ack,
    output logic        rsp1_val,
    output logic [3:0]  rsp1_returntype,
    output logic [63:0] rsp1_data_0,
    output logic [63:0] rsp1_data_1,
    output logic        rsp1_timeout,

    output logic [3:0]  core_l15_rqtype,
    output logic [2:0]  core_l15_size,
    output logic [31:0] core_l15_address,
    output logic [31:0] core_l15_data,
    output logic        core_l15_val,
    input  logic        l15_core_ack,
    input  logic        l15_core_header_ack,

    input  logic        l15_core_val,
    input  logic [3:0]  l15_core_returntype,
    input  logic [63:0] l15_core_data_0,
    input  logic [63:0] l15_core_data_1,
    output logic        core_l15_req_ack,

    output logic        int_val,
    output logic        busy
);

    localparam logic [3:0] LOAD_RQ  = 4'b0000;
    localparam logic [3:0] STORE_RQ = 4'b0001;
    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam logic [3:0] ST_ACK   = 4'b0100;
    localparam logic [3:0] INT_RET  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         rqtype_q, rqtype_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        address_q, address_d;
    logic [31:0]        data_q, data_d;
    logic               rsp0_val_q, rsp0_val_d, rsp1_val_q, rsp1_val_d;
    logic               rsp0_timeout_q, rsp0_timeout_d, rsp1_timeout_q, rsp1_timeout_d;
    logic               int_val_q, int_val_d;
    logic [3:0]         rsp0_rt_q, rsp0_rt_d, rsp1_rt_q, rsp1_rt_d;
    logic [63:0]        rsp0_d0_q, rsp0_d0_d, rsp0_d1_q, rsp0_d1_d;
    logic [63:0]        rsp1_d0_q, rsp1_d0_d, rsp1_d1_q, rsp1_d1_d;

    logic               winner;
    logic               rsp_match;
    logic               l15_accept;

    assign l15_accept = l15_core_ack & l15_core_header_ack;

    // Only the returntype paired with the captured request type completes a transaction
    assign rsp_match = l15_core_val &
                       (((rqtype_q == LOAD_RQ)  && (l15_core_returntype == LOAD_RET)) ||
                        ((rqtype_q == STORE_RQ) && (l15_core_returntype == ST_ACK)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= S_IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            cnt_q          <= '0;
            rqtype_q       <= '0;
            size_q         <= '0;
            address_q      <= '0;
            data_q         <= '0;
            rsp0_val_q     <= 1'b0;
            rsp1_val_q     <= 1'b0;
            rsp0_timeout_q <= 1'b0;
            rsp1_timeout_q <= 1'b0;
            int_val_q      <= 1'b0;
            rsp0_rt_q      <= '0;
            rsp1_rt_q      <= '0;
            rsp0_d0_q      <= '0;
            rsp0_d1_q      <= '0;
            rsp1_d0_q      <= '0;
            rsp1_d1_q      <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            rqtype_q       <= rqtype_d;
            size_q         <= size_d;
            address_q      <= address_d;
            data_q         <= data_d;
            rsp0_val_q     <= rsp0_val_d;
            rsp1_val_q     <= rsp1_val_d;
            rsp0_timeout_q <= rsp0_timeout_d;
            rsp1_timeout_q <= rsp1_timeout_d;
            int_val_q      <= int_val_d;
            rsp0_rt_q      <= rsp0_rt_d;
            rsp1_rt_q      <= rsp1_rt_d;
            rsp0_d0_q      <= rsp0_d0_d;
            rsp0_d1_q      <= rsp0_d1_d;
            rsp1_d0_q      <= rsp1_d0_d;
            rsp1_d1_q      <= rsp1_d1_d;
        end
    end

    // Next state, capture and response registers
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        rqtype_d       = rqtype_q;
        size_d         = size_q;
        address_d      = address_q;
        data_d         = data_q;
        rsp0_val_d     = 1'b0;
        rsp1_val_d     = 1'b0;
        rsp0_timeout_d = 1'b0;
        rsp1_timeout_d = 1'b0;
        int_val_d      = l15_core_val & (l15_core_returntype == INT_RET);
        rsp0_rt_d      = rsp0_rt_q;
        rsp1_rt_d      = rsp1_rt_q;
        rsp0_d0_d      = rsp0_d0_q;
        rsp0_d1_d      = rsp0_d1_q;
        rsp1_d0_d      = rsp1_d0_q;
        rsp1_d1_d      = rsp1_d1_q;
        winner         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rq0_val || rq1_val) begin
                    winner       = (rq0_val && rq1_val) ? ~last_grant_q : rq1_val;
                    rqtype_d     = winner ? rq1_rqtype  : rq0_rqtype;
                    size_d       = winner ? rq1_size    : rq0_size;
                    address_d    = winner ? rq1_address : rq0_address;
                    data_d       = winner ? rq1_data    : rq0_data;
                    owner_d      = winner;
                    last_grant_d = winner;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (l15_accept) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_match) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        rsp1_val_d = 1'b1;
                        rsp1_rt_d  = l15_core_returntype;
                        rsp1_d0_d  = l15_core_data_0;
                        rsp1_d1_d  = l15_core_data_1;
                    end else begin
                        rsp0_val_d = 1'b1;
                        rsp0_rt_d  = l15_core_returntype;
                        rsp0_d0_d  = l15_core_data_0;
                        rsp0_d1_d  = l15_core_data_1;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
                    state_d        = S_IDLE;
                    rsp0_timeout_d = ~owner_q;
                    rsp1_timeout_d = owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded and pass-through handshake outputs
    always_comb begin
        core_l15_val     = 1'b0;
        rq0_ack          = 1'b0;
        rq1_ack          = 1'b0;
        busy             = (state_q != S_IDLE);
        // Every L1.5 response is consumed: matched, interrupt, stray or late
        core_l15_req_ack = l15_core_val;
        if (state_q == S_REQ) begin
            core_l15_val = 1'b1;
            rq0_ack      = l15_accept & ~owner_q;
            rq1_ack      = l15_accept &  owner_q;
        end
    end

    assign core_l15_rqtype  = rqtype_q;
    assign core_l15_size    = size_q;
    assign core_l15_address = address_q;
    assign core_l15_data    = data_q;

    assign rsp0_val         = rsp0_val_q;
    assign rsp1_val         = rsp1_val_q;
    assign rsp0_timeout     = rsp0_timeout_q;
    assign rsp1_timeout     = rsp1_timeout_q;
    assign int_val          = int_val_q;
    assign rsp0_returntype  = rsp0_rt_q;
    assign rsp1_returntype  = rsp1_rt_q;
    assign rsp0_data_0      = rsp0_d0_q;
    assign rsp0_data_1      = rsp0_d1_q;
    assign rsp1_data_0      = rsp1_d0_q;
    assign rsp1_data_1      = rsp1_d1_q;

endmodule

// File: tb/tb_l15_port_arbiter.sv
// Scenario-driven bench for l15_port_arbiter: directed cases plus randomized
// transactions checked against a round-robin reference model.
module tb_l15_port_arbiter;

    localparam int unsigned TO = 8;
    localparam logic [3:0] LOAD_RQ  = 4'b0000;
    localparam logic [3:0] STORE_RQ = 4'b0001;
    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam logic [3:0] ST_ACK   = 4'b0100;
    localparam logic [3:0] INT_RET  = 4'b0111;

    logic        clk = 1'b0;
    logic        nrst;
    logic        rq0_val, rq1_val;
    logic [3:0]  rq0_rqtype, rq1_rqtype;
    logic [2:0]  rq0_size, rq1_size;
    logic [31:0] rq0_address, rq1_address, rq0_data, rq1_data;
    logic        rq0_ack, rq1_ack;
    logic        rsp0_val, rsp1_val, rsp0_timeout, rsp1_timeout;
    logic [3:0]  rsp0_returntype, rsp1_returntype;
    logic [63:0] rsp0_data_0, rsp0_data_1, rsp1_data_0, rsp1_data_1;
    logic [3:0]  core_l15_rqtype;
    logic [2:0]  core_l15_size;
    logic [31:0] core_l15_address, core_l15_data;
    logic        core_l15_val, l15_core_ack, l15_core_header_ack;
    logic        l15_core_val;
    logic [3:0]  l15_core_returntype;
    logic [63:0] l15_core_data_0, l15_core_data_1;
    logic        core_l15_req_ack, int_val, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;

    always #5 clk = ~clk;

    l15_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk(clk), .nrst(nrst),
        .rq0_val(rq0_val), .rq0_rqtype(rq0_rqtype), .rq0_size(rq0_size),
        .rq0_address(rq0_address), .rq0_data(rq0_data), .rq0_ack(rq0_ack),
        .rsp0_val(rsp0_val), .rsp0_returntype(rsp0_returntype),
        .rsp0_data_0(rsp0_data_0), .rsp0_data_1(rsp0_data_1), .rsp0_timeout(rsp0_timeout),
        .rq1_val(rq1_val), .rq1_rqtype(rq1_rqtype), .rq1_size(rq1_size),
        .rq1_address(rq1_address), .rq1_data(rq1_data), .rq1_ack(rq1_ack),
        .rsp1_val(rsp1_val), .rsp1_returntype(rsp1_returntype),
        .rsp1_data_0(rsp1_data_0), .rsp1_data_1(rsp1_data_1), .rsp1_timeout(rsp1_timeout),
        .core_l15_rqtype(core_l15_rqtype), .core_l15_size(core_l15_size),
        .core_l15_address(core_l15_address), .core_l15_data(core_l15_data),
        .core_l15_val(core_l15_val), .l15_core_ack(l15_core_ack),
        .l15_core_header_ack(l15_core_header_ack),
        .l15_core_val(l15_core_val), .l15_core_returntype(l15_core_returntype),
        .l15_core_data_0(l15_core_data_0), .l15_core_data_1(l15_core_data_1),
        .core_l15_req_ack(core_l15_req_ack), .int_val(int_val), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rq0_val = 0; rq0_rqtype = 0; rq0_size = 0; rq0_address = 0; rq0_data = 0;
        rq1_val = 0; rq1_rqtype = 0; rq1_size = 0; rq1_address = 0; rq1_data = 0;
        l15_core_ack = 0; l15_core_header_ack = 0; l15_core_val = 0;
        l15_core_returntype = 0; l15_core_data_0 = 0; l15_core_data_1 = 0;
    endtask

    task automatic do_reset();
        nrst = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        nrst = 1;
        model_last = 1;
    endtask

    // Plays the L1.5 side of one transaction and reports what the DUT did
    task automatic serve_one(
        input  int          ack_dly, input int rsp_dly, input logic [3:0] rt,
        input  logic [63:0] d0, input logic [63:0] d1,
        input  bit          reassert, input bit scramble, input bit int_first,
        output int          gnt, output logic [31:0] addr, output logic [3:0] typ,
        output logic [31:0] data, output logic [2:0] size, output bit hold_ok,
        output bit          rack_ok, output int rsp_who, output logic [63:0] o_d0,
        output logic [63:0] o_d1, output logic [3:0] o_rt, output bit int_seen,
        output bit          busy_int);
        bit found = 0;
        gnt = -1; addr = 0; typ = 0; data = 0; size = 0; hold_ok = 0; rack_ok = 0;
        rsp_who = -1; o_d0 = 0; o_d1 = 0; o_rt = 0; int_seen = 0; busy_int = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); #1;
            if (core_l15_val === 1'b1) found = 1;
        end
        if (!found) return;
        addr = core_l15_address; typ = core_l15_rqtype; data = core_l15_data;
        size = core_l15_size; hold_ok = 1;
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            if (scramble) rq0_address = $urandom;
            #1;
            if (core_l15_val !== 1'b1 || core_l15_address !== addr) hold_ok = 0;
        end
        tick();
        l15_core_ack = 1; l15_core_header_ack = 1;
        #1;
        if (core_l15_val !== 1'b1) hold_ok = 0;
        if (rq0_ack === 1'b1 && rq1_ack === 1'b1) gnt = 3;
        else if (rq0_ack === 1'b1) gnt = 0;
        else if (rq1_ack === 1'b1) gnt = 1;
        tick();
        l15_core_ack = 0; l15_core_header_ack = 0;
        if (gnt == 0) rq0_val = 0;
        if (gnt == 1) rq1_val = 0;
        for (int i = 0; i < rsp_dly; i++) tick();
        if (int_first) begin
            l15_core_val = 1; l15_core_returntype = INT_RET;
            tick();
            l15_core_val = 0; l15_core_returntype = 0;
            #1;
            int_seen = (int_val === 1'b1);
            busy_int = (busy === 1'b1);
            tick();
        end
        l15_core_val = 1; l15_core_returntype = rt;
        l15_core_data_0 = d0; l15_core_data_1 = d1;
        if (reassert && gnt == 0) rq0_val = 1;
        if (reassert && gnt == 1) rq1_val = 1;
        #1;
        rack_ok = (core_l15_req_ack === 1'b1);
        tick();
        l15_core_val = 0; l15_core_returntype = 0;
        #1;
        if (rsp0_val === 1'b1 && rsp1_val === 1'b1) rsp_who = 3;
        else if (rsp0_val === 1'b1) begin
            rsp_who = 0; o_d0 = rsp0_data_0; o_d1 = rsp0_data_1; o_rt = rsp0_returntype;
        end else if (rsp1_val === 1'b1) begin
            rsp_who = 1; o_d0 = rsp1_data_0; o_d1 = rsp1_data_1; o_rt = rsp1_returntype;
        end
    endtask

    task automatic test_reset();
        logic [11:0] flags;
        nrst = 0;
        idle_inputs();
        #3;
        flags = {busy, core_l15_val, rq0_ack, rq1_ack, rsp0_val, rsp1_val, rsp0_timeout,
                 rsp1_timeout, int_val, core_l15_req_ack, |core_l15_rqtype, |core_l15_size};
        n_checks++;
        if (flags !== 12'h0) begin
            n_fail++; $display("FAIL reset_flags: got %h expected 000", flags);
        end
        n_checks++;
        if ({core_l15_address, core_l15_data, rsp0_data_0, rsp1_data_1, rsp0_returntype} !== '0) begin
            n_fail++; $display("FAIL reset_data: got addr %h data %h expected all zero",
                               core_l15_address, core_l15_data);
        end
        do_reset();
    endtask

    task automatic test_single_load();
        int gnt, who; logic [31:0] a, d; logic [3:0] t, rt; logic [2:0] s;
        bit hok, rok, is, bi; logic [63:0] o0, o1;
        do_reset();
        rq1_val = 1; rq1_rqtype = LOAD_RQ; rq1_size = 3'b011; rq1_address = 32'h1004;
        serve_one(2, 2, LOAD_RET, 64'h1122334455667788, 64'h0BADF00D, 0, 0, 0,
                  gnt, a, t, d, s, hok, rok, who, o0, o1, rt, is, bi);
        n_checks++;
        if (gnt !== 1 || a !== 32'h1004 || t !== LOAD_RQ || s !== 3'b011) begin
            n_fail++; $display("FAIL single_grant: got gnt %0d addr %h type %h size %0d expected 1 1004 0 3", gnt, a, t, s);
        end
        n_checks++;
        if (!rok) begin n_fail++; $display("FAIL single_req_ack: got 0 expected 1"); end
        n_checks++;
        if (who !== 1 || o0 !== 64'h1122334455667788 || o1 !== 64'h0BADF00D || rt !== LOAD_RET) begin
            n_fail++; $display("FAIL single_rsp: got who %0d d0 %h d1 %h rt %h expected 1 1122334455667788 0badf00d 0", who, o0, o1, rt);
        end
        tick(); #1;
        n_checks++;
        if (rsp1_val !== 1'b0 || rsp0_val !== 1'b0 || busy !== 1'b0 || rsp1_data_0 !== 64'h1122334455667788) begin
            n_fail++; $display("FAIL single_pulse_hold: got rsp1 %b rsp0 %b busy %b d0 %h expected 0 0 0 1122334455667788", rsp1_val, rsp0_val, busy, rsp1_data_0);
        end
    endtask

    task automatic test_round_robin();
        int gnt, who, exp; logic [31:0] a, d; logic [3:0] t, rt; logic [2:0] s;
        bit hok, rok, is, bi; logic [63:0] o0, o1, r0;
        do_reset();
        rq0_val = 1; rq0_address = 32'hA000_0000; rq0_rqtype = LOAD_RQ;
        rq1_val = 1; rq1_address = 32'hB000_0004; rq1_rqtype = LOAD_RQ;
        for (int g = 0; g < 4; g++) begin
            exp = 1 - model_last;
            model_last = exp;
            r0 = {$urandom, $urandom};
            serve_one($urandom_range(0, 3), $urandom_range(0, 4), LOAD_RET, r0, 64'h0, 1, 0, 0,
                      gnt, a, t, d, s, hok, rok, who, o0, o1, rt, is, bi);
            n_checks++;
            if (gnt !== exp || a !== (exp ? 32'hB000_0004 : 32'hA000_0000)) begin
                n_fail++; $display("FAIL rr_grant%0d: got gnt %0d addr %h expected %0d", g, gnt, a, exp);
            end
            n_checks++;
            if (who !== exp || o0 !== r0) begin
                n_fail++; $display("FAIL rr_rsp%0d: got who %0d d0 %h expected %0d %h", g, who, o0, exp, r0);
            end
        end
    endtask

    task automatic test_int_store();
        int gnt, who; logic [31:0] a, d; logic [3:0] t, rt; logic [2:0] s;
        bit hok, rok, is, bi; logic [63:0] o0, o1;
        do_reset();
        rq1_val = 1; rq1_rqtype = STORE_RQ; rq1_size = 3'b001;
        rq1_address = 32'h2002; rq1_data = 32'hBEEF_0000;
        serve_one(1, 1, ST_ACK, 64'h77, 64'h88, 0, 0, 1,
                  gnt, a, t, d, s, hok, rok, who, o0, o1, rt, is, bi);
        n_checks++;
        if (gnt !== 1 || t !== STORE_RQ || s !== 3'b001 || a !== 32'h2002 || d !== 32'hBEEF_0000) begin
            n_fail++; $display("FAIL store_capture: got gnt %0d type %h size %0d addr %h data %h expected 1 1 1 2002 beef0000", gnt, t, s, a, d);
        end
        n_checks++;
        if (!is || !bi) begin
            n_fail++; $display("FAIL int_pulse: got int %b busy %b expected 1 1", is, bi);
        end
        n_checks++;
        if (who !== 1 || rt !== ST_ACK) begin
            n_fail++; $display("FAIL store_rsp: got who %0d rt %h expected 1 4", who, rt);
        end
    endtask

    task automatic test_stray();
        do_reset();
        l15_core_val = 1; l15_core_returntype = LOAD_RET;
        #1;
        n_checks++;
        if (core_l15_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL stray_ack: got %b expected 1", core_l15_req_ack);
        end
        tick();
        l15_core_returntype = INT_RET;
        #1;
        n_checks++;
        if ({rsp0_val, rsp1_val, busy, int_val} !== 4'b0000) begin
            n_fail++; $display("FAIL stray_drop: got rsp0/rsp1/busy/int %b expected 0000", {rsp0_val, rsp1_val, busy, int_val});
        end
        tick();
        l15_core_val = 0; l15_core_returntype = 0;
        #1;
        n_checks++;
        if (int_val !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_int: got int %b busy %b expected 1 0", int_val, busy);
        end
        tick(); #1;
        n_checks++;
        if (int_val !== 1'b0) begin
            n_fail++; $display("FAIL int_one_pulse: got %b expected 0", int_val);
        end
    endtask

    task automatic test_timeout();
        int first_k = -1; int n_to = 0; bit other = 0; bit late_ack;
        do_reset();
        rq0_val = 1; rq0_rqtype = LOAD_RQ; rq0_address = 32'h3000;
        tick();
        l15_core_ack = 1; l15_core_header_ack = 1;
        tick();
        l15_core_ack = 0; l15_core_header_ack = 0; rq0_val = 0;
        for (int k = 0; k < 13; k++) begin
            #1;
            if (rsp0_timeout === 1'b1) begin
                n_to++;
                if (first_k < 0) first_k = k;
            end
            if (rsp1_timeout === 1'b1 || rsp0_val === 1'b1) other = 1;
            tick();
        end
        n_checks++;
        if (first_k != int'(TO) + 1 || n_to != 1) begin
            n_fail++; $display("FAIL timeout_cycle: got first %0d count %0d expected %0d 1", first_k, n_to, TO + 1);
        end
        n_checks++;
        if (other || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_side: got stray %b busy %b expected 0 0", other, busy);
        end
        l15_core_val = 1; l15_core_returntype = LOAD_RET; l15_core_data_0 = 64'h55;
        #1;
        late_ack = core_l15_req_ack;
        tick();
        l15_core_val = 0;
        #1;
        n_checks++;
        if (late_ack !== 1'b1 || rsp0_val !== 1'b0 || rsp1_val !== 1'b0) begin
            n_fail++; $display("FAIL late_rsp: got ack %b rsp0 %b rsp1 %b expected 1 0 0", late_ack, rsp0_val, rsp1_val);
        end
    endtask

    task automatic test_reset_mid();
        int gnt, who; logic [31:0] a, d; logic [3:0] t, rt; logic [2:0] s;
        bit hok, rok, is, bi; logic [63:0] o0, o1;
        do_reset();
        rq0_val = 1; rq0_rqtype = LOAD_RQ; rq0_address = 32'h4000;
        serve_one(0, 0, LOAD_RET, 64'hAAAA, 64'hBBBB, 0, 0, 0,
                  gnt, a, t, d, s, hok, rok, who, o0, o1, rt, is, bi);
        rq0_val = 1;
        tick();
        l15_core_ack = 1; l15_core_header_ack = 1;
        tick();
        l15_core_ack = 0; l15_core_header_ack = 0; rq0_val = 0;
        tick();
        nrst = 0;
        #1;
        n_checks++;
        if ({busy, core_l15_val, rsp0_val, rsp0_timeout, int_val} !== 5'b0 ||
            rsp0_data_0 !== 64'h0 || core_l15_address !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: got busy %b val %b d0 %h addr %h expected 0 0 0 0", busy, core_l15_val, rsp0_data_0, core_l15_address);
        end
        tick();
        nrst = 1;
        model_last = 1;
        rq0_val = 1; rq0_address = 32'h4400;
        serve_one(1, 1, LOAD_RET, 64'hCCCC, 64'hDDDD, 0, 0, 0,
                  gnt, a, t, d, s, hok, rok, who, o0, o1, rt, is, bi);
        n_checks++;
        if (gnt !== 0 || a !== 32'h4400 || who !== 0 || o0 !== 64'hCCCC) begin
            n_fail++; $display("FAIL after_reset: got gnt %0d addr %h who %0d d0 %h expected 0 4400 0 cccc", gnt, a, who, o0);
        end
    endtask

    task automatic test_hold();
        int gnt, who; logic [31:0] a, d; logic [3:0] t, rt; logic [2:0] s;
        bit hok, rok, is, bi; logic [63:0] o0, o1;
        do_reset();
        rq0_val = 1; rq0_rqtype = LOAD_RQ; rq0_address = 32'h5550;
        serve_one(5, 0, LOAD_RET, 64'h1, 64'h2, 0, 1, 0,
                  gnt, a, t, d, s, hok, rok, who, o0, o1, rt, is, bi);
        n_checks++;
        if (a !== 32'h5550 || !hok || gnt !== 0) begin
            n_fail++; $display("FAIL hold_stable: got addr %h stable %b gnt %0d expected 5550 1 0", a, hok, gnt);
        end
    endtask

    task automatic test_random();
        bit pend [2]; logic [3:0] ft [2]; logic [2:0] fs [2]; logic [31:0] fa [2], fd [2];
        int gnt, who, win; logic [31:0] a, d; logic [3:0] t, rt, exp_rt; logic [2:0] s;
        bit hok, rok, is, bi, re; logic [63:0] o0, o1, r0, r1;
        do_reset();
        pend[0] = 0; pend[1] = 0;
        for (int it = 0; it < 16; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1 || (r == 1 && !pend[0]))) begin
                    pend[r] = 1;
                    ft[r] = ($urandom_range(0, 1) == 1) ? STORE_RQ : LOAD_RQ;
                    fs[r] = 3'($urandom_range(0, 7));
                    fa[r] = $urandom; fd[r] = $urandom;
                    if (r == 0) begin
                        rq0_val = 1; rq0_rqtype = ft[0]; rq0_size = fs[0];
                        rq0_address = fa[0]; rq0_data = fd[0];
                    end else begin
                        rq1_val = 1; rq1_rqtype = ft[1]; rq1_size = fs[1];
                        rq1_address = fa[1]; rq1_data = fd[1];
                    end
                end
            end
            win = (pend[0] && pend[1]) ? 1 - model_last : (pend[1] ? 1 : 0);
            model_last = win;
            exp_rt = (ft[win] == STORE_RQ) ? ST_ACK : LOAD_RET;
            r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom};
            re = ($urandom_range(0, 1) == 1);
            serve_one($urandom_range(0, 3), $urandom_range(0, 4), exp_rt, r0, r1, re, 0, 0,
                      gnt, a, t, d, s, hok, rok, who, o0, o1, rt, is, bi);
            pend[win] = re;
            n_checks++;
            if (gnt !== win || a !== fa[win] || t !== ft[win] || s !== fs[win] || d !== fd[win]) begin
                n_fail++; $display("FAIL rand_req%0d: got gnt %0d addr %h type %h expected %0d %h %h", it, gnt, a, t, win, fa[win], ft[win]);
            end
            n_checks++;
            if (who !== win || o0 !== r0 || o1 !== r1 || rt !== exp_rt || !rok) begin
                n_fail++; $display("FAIL rand_rsp%0d: got who %0d d0 %h rt %h ack %b expected %0d %h %h 1", it, who, o0, rt, rok, win, r0, exp_rt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_int_store();
        test_stray();
        test_timeout();
        test_reset_mid();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
